// File: rtl/v68k_bus_ctrl.sv
// v68k_bus_ctrl: bus interface unit between the v68k sequencer and a
// 68000-style asynchronous bus. It takes one byte, word or long request at a
// time over req/ack, runs one or two word bus cycles, and returns
// zero-extended read data.
//
// Optional feature: define V68K_BUS_TIMEOUT_EN to turn a WAIT state that
// lasts TIMEOUT_CYCLES cycles into a bus error.
//
// Ports:
//   CLK, RESET           clock, synchronous active-high reset
//   req/we/size/addr     core request (held until ack), write enable,
//                        size 00=byte 01=word 10=long 11=word
//   wdata                write data (byte [7:0], word [15:0], long [31:0])
//   ack/err/rdata        one-cycle completion pulse, error flag, read data
//   A, AS, UDS, LDS, RW  external address bus and strobes (active-low)
//   D                    bidirectional data bus, driven only while writing
//   DTACK, BERR          asynchronous active-low terminations
module v68k_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic [23:1] A,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic        RW,
  inout  wire  [15:0] D,
  input  logic        DTACK,
  input  logic        BERR
);

  localparam int unsigned AW = 24;
  localparam int unsigned BW = 16;
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    STRB = 3'd2,
    WAIT = 3'd3,
    TERM = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t          state, state_nxt;

  // Latched request context
  logic [AW-1:0]   addr_q, addr_nxt;
  logic [DW-1:0]   wdata_q, wdata_nxt;
  logic            we_q, we_nxt;
  logic            byte_q, byte_nxt;
  logic            long_q, long_nxt;
  logic            second_q, second_nxt;
  logic            berr_q, berr_nxt;
  logic [BW-1:0]   buf_hi, buf_hi_nxt;
  logic [BW-1:0]   buf_lo, buf_lo_nxt;

  // Next values of the registered bus/core outputs
  logic            ack_nxt, err_nxt, as_nxt, uds_nxt, lds_nxt, rw_nxt;
  logic            d_oe, d_oe_nxt, ds_active;
  logic [BW-1:0]   d_out, d_out_nxt;
  logic [DW-1:0]   rdata_nxt, rd_asm;

  // Two-flop synchronisers for the asynchronous terminations
  logic            dtack_m, dtack_s, berr_m, berr_s;

`ifdef V68K_BUS_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
`endif

  assign D = d_oe ? d_out : 16'hzzzz;

  // Synchronisers, preset to the negated level on reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      dtack_m <= 1'b1;
      dtack_s <= 1'b1;
      berr_m  <= 1'b1;
      berr_s  <= 1'b1;
    end else begin
      dtack_m <= DTACK;
      dtack_s <= dtack_m;
      berr_m  <= BERR;
      berr_s  <= berr_m;
    end
  end

  // State, context and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      byte_q   <= 1'b0;
      long_q   <= 1'b0;
      second_q <= 1'b0;
      berr_q   <= 1'b0;
      buf_hi   <= '0;
      buf_lo   <= '0;
      ack      <= 1'b0;
      err      <= 1'b0;
      rdata    <= '0;
      A        <= '0;
      AS       <= 1'b1;
      UDS      <= 1'b1;
      LDS      <= 1'b1;
      RW       <= 1'b1;
      d_oe     <= 1'b0;
      d_out    <= '0;
`ifdef V68K_BUS_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state    <= state_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
      we_q     <= we_nxt;
      byte_q   <= byte_nxt;
      long_q   <= long_nxt;
      second_q <= second_nxt;
      berr_q   <= berr_nxt;
      buf_hi   <= buf_hi_nxt;
      buf_lo   <= buf_lo_nxt;
      ack      <= ack_nxt;
      err      <= err_nxt;
      rdata    <= rdata_nxt;
      A        <= addr_nxt[23:1];
      AS       <= as_nxt;
      UDS      <= uds_nxt;
      LDS      <= lds_nxt;
      RW       <= rw_nxt;
      d_oe     <= d_oe_nxt;
      d_out    <= d_out_nxt;
`ifdef V68K_BUS_TIMEOUT_EN
      cnt_q    <= cnt_nxt;
`endif
    end
  end

  // Read data assembly from the word buffers; a bus error returns zero
  always_comb begin
    rd_asm = '0;
    if (!berr_nxt) begin
      if (long_q)
        rd_asm = {buf_hi, buf_lo};
      else if (byte_q)
        rd_asm = DW'(addr_q[0] ? buf_lo[7:0] : buf_lo[15:8]);
      else
        rd_asm = DW'(buf_lo);
    end
  end

  // Next state and next registered outputs
  always_comb begin
    state_nxt  = state;
    addr_nxt   = addr_q;
    wdata_nxt  = wdata_q;
    we_nxt     = we_q;
    byte_nxt   = byte_q;
    long_nxt   = long_q;
    second_nxt = second_q;
    berr_nxt   = berr_q;
    buf_hi_nxt = buf_hi;
    buf_lo_nxt = buf_lo;
`ifdef V68K_BUS_TIMEOUT_EN
    cnt_nxt    = cnt_q;
`endif

    unique case (state)
      IDLE: begin
        if (req) begin
          if (addr[0] && (size != 2'b00)) begin
            // Address error: answer without touching the bus
            berr_nxt  = 1'b1;
            state_nxt = DONE;
          end else begin
            addr_nxt   = addr;
            wdata_nxt  = wdata;
            we_nxt     = we;
            byte_nxt   = (size == 2'b00);
            long_nxt   = (size == 2'b10);
            second_nxt = 1'b0;
            berr_nxt   = 1'b0;
            state_nxt  = ADDR;
          end
        end
      end
      ADDR: state_nxt = STRB;
      STRB: begin
        state_nxt = WAIT;
`ifdef V68K_BUS_TIMEOUT_EN
        cnt_nxt   = '0;
`endif
      end
      WAIT: begin
        // BERR wins over a simultaneous DTACK
        if (!berr_s) begin
          berr_nxt  = 1'b1;
          state_nxt = TERM;
        end else if (!dtack_s) begin
          if (long_q && !second_q)
            buf_hi_nxt = D;
          else
            buf_lo_nxt = D;
          state_nxt = TERM;
        end
`ifdef V68K_BUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          berr_nxt  = 1'b1;
          state_nxt = TERM;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
`endif
      end
      TERM: begin
        if (long_q && !second_q && !berr_q) begin
          second_nxt = 1'b1;
          addr_nxt   = addr_q + AW'(2);
          state_nxt  = ADDR;
        end else begin
          state_nxt = DONE;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    // Bus outputs are decoded from the state being entered so they are
    // registered and glitch-free during each bus phase.
    ds_active = (state_nxt == WAIT) || ((state_nxt == STRB) && !we_nxt);
    as_nxt    = !((state_nxt == STRB) || (state_nxt == WAIT));
    uds_nxt   = !(ds_active && (!byte_nxt || !addr_nxt[0]));
    lds_nxt   = !(ds_active && (!byte_nxt || addr_nxt[0]));
    rw_nxt    = ((state_nxt == ADDR) || (state_nxt == STRB) || (state_nxt == WAIT))
                ? !we_nxt : 1'b1;
    d_oe_nxt  = we_nxt && ((state_nxt == STRB) || (state_nxt == WAIT));
    if (byte_nxt)
      d_out_nxt = {wdata_nxt[7:0], wdata_nxt[7:0]};
    else if (long_nxt && !second_nxt)
      d_out_nxt = wdata_nxt[31:16];
    else
      d_out_nxt = wdata_nxt[15:0];

    ack_nxt   = (state_nxt == DONE);
    err_nxt   = (state_nxt == DONE) && berr_nxt;
    rdata_nxt = (state_nxt == DONE) ? rd_asm : '0;
  end

endmodule

// File: tb/tb_v68k_bus_ctrl.sv
// Directed bench for v68k_bus_ctrl with a tiny bus slave model.
module tb_v68k_bus_ctrl;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req, we;
  logic [1:0]  size;
  logic [23:0] addr;
  logic [31:0] wdata;
  logic        ack, err;
  logic [31:0] rdata;
  logic [23:1] A;
  logic        AS, UDS, LDS, RW;
  wire  [15:0] D;
  logic        DTACK, BERR;

  // Slave read data: even word address vs odd word address
  logic [15:0] dev_even, dev_odd;

  int vectors = 0;
  int miscompares = 0;

  // Per-transaction observations
  int          n_edges;
  int          as_falls;
  logic [23:1] a_first, a_second;
  logic        uds_low, lds_low, rw_at_as;
  logic [15:0] d_wr, d_after_term;
  logic        strobes_at_ack;
  logic        got_ack, got_err;
  logic [31:0] got_rdata;

  always #5 CLK = ~CLK;

  pullup (D);
  assign D = (!AS && RW) ? (A[1] ? dev_odd : dev_even) : 16'hzzzz;

  v68k_bus_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .CLK(CLK), .RESET(RESET), .req(req), .we(we), .size(size), .addr(addr),
    .wdata(wdata), .ack(ack), .err(err), .rdata(rdata), .A(A), .AS(AS),
    .UDS(UDS), .LDS(LDS), .RW(RW), .D(D), .DTACK(DTACK), .BERR(BERR)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and watch the bus until ack; BERR is pulled low
  // berr_at cycles after AS falls when berr_at >= 0.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic [23:0] ad,
                         input logic [31:0] wd, input int berr_at);
    logic prev_as;
    int   as_cnt;
    n_edges = 0; as_falls = 0; a_first = '0; a_second = '0;
    uds_low = 1'b0; lds_low = 1'b0; rw_at_as = 1'b1;
    d_wr = '0; d_after_term = '0; got_ack = 1'b0; got_err = 1'b0;
    got_rdata = '0; strobes_at_ack = 1'b0;
    prev_as = AS; as_cnt = 0;
    req = 1'b1; we = w; size = sz; addr = ad; wdata = wd;
    while (!got_ack && n_edges < 200) begin
      @(posedge CLK); #1;
      n_edges++;
      if (!AS) begin
        if (prev_as) begin
          as_falls++;
          if (as_falls == 1) a_first = A; else a_second = A;
          rw_at_as = RW;
        end
        as_cnt++;
        if (berr_at >= 0 && as_cnt == berr_at) BERR = 1'b0;
        if (!UDS) uds_low = 1'b1;
        if (!LDS) lds_low = 1'b1;
        if (!RW && (!UDS || !LDS)) d_wr = D;
      end else if (!prev_as) begin
        d_after_term = D;
      end
      prev_as = AS;
      if (ack) begin
        got_ack = 1'b1; got_err = err; got_rdata = rdata;
        strobes_at_ack = AS & UDS & LDS;
      end
    end
    req = 1'b0;
    if (!got_ack) check("ack_timeout", 32'(n_edges), 32'd0);
    BERR = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
  endtask

  initial begin
    int ack_seen;
    RESET = 1'b1; req = 1'b0; we = 1'b0; size = 2'b01; addr = '0; wdata = '0;
    DTACK = 1'b0; BERR = 1'b1; dev_even = 16'h0000; dev_odd = 16'h0000;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_as",    32'(AS),  32'd1);
    check("rst_ds",    32'({UDS, LDS}), 32'd3);
    check("rst_rw",    32'(RW),  32'd1);
    check("rst_ack",   32'({ack, err}), 32'd0);
    check("rst_rdata", rdata,    32'd0);
    check("rst_a",     32'(A),   32'd0);
    check("rst_d",     32'(D),   32'h0000FFFF);
    RESET = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Word read
    dev_even = 16'h4E71;
    run_req(1'b0, 2'b01, 24'h000100, 32'h0, -1);
    check("wr_rd_a",     32'(a_first), 32'h80);
    check("wr_rd_ds",    32'({uds_low, lds_low}), 32'd3);
    check("wr_rd_rw",    32'(rw_at_as), 32'd1);
    check("wr_rd_lat",   32'(n_edges), 32'd5);
    check("wr_rd_rdata", got_rdata, 32'h00004E71);
    check("wr_rd_err",   32'(got_err), 32'd0);

    // Byte write to odd address
    run_req(1'b1, 2'b00, 24'h000201, 32'h000000A5, -1);
    check("bw_lds",    32'(lds_low), 32'd1);
    check("bw_uds",    32'(uds_low), 32'd0);
    check("bw_rw",     32'(rw_at_as), 32'd0);
    check("bw_d",      32'(d_wr), 32'h0000A5A5);
    check("bw_d_rel",  32'(d_after_term), 32'h0000FFFF);
    check("bw_err",    32'({got_ack, got_err}), 32'd2);

    // Byte read from even address picks D[15:8]
    dev_even = 16'hBEEF;
    run_req(1'b0, 2'b00, 24'h000300, 32'h0, -1);
    check("br_ds",    32'({uds_low, lds_low}), 32'd2);
    check("br_rdata", got_rdata, 32'h000000BE);

    // Long read: two word cycles
    dev_even = 16'h1234; dev_odd = 16'h5678;
    run_req(1'b0, 2'b10, 24'h000400, 32'h0, -1);
    check("lr_a1",    32'(a_first),  32'h200);
    check("lr_a2",    32'(a_second), 32'h201);
    check("lr_falls", 32'(as_falls), 32'd2);
    check("lr_lat",   32'(n_edges),  32'd9);
    check("lr_rdata", got_rdata,     32'h12345678);

    // Misaligned word read
    run_req(1'b0, 2'b01, 24'h000003, 32'h0, -1);
    check("ma_falls", 32'(as_falls), 32'd0);
    check("ma_lat",   32'(n_edges),  32'd1);
    check("ma_err",   32'(got_err),  32'd1);

    // BERR ten cycles into the cycle, DTACK held high
    DTACK = 1'b1;
    run_req(1'b0, 2'b01, 24'h000100, 32'h0, 10);
    check("be_err",     32'(got_err), 32'd1);
    check("be_rdata",   got_rdata,    32'd0);
    check("be_strobes", 32'(strobes_at_ack), 32'd1);

    // BERR and DTACK together: BERR wins
    DTACK = 1'b0; BERR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    run_req(1'b0, 2'b01, 24'h000100, 32'h0, 0);
    check("bd_err",   32'(got_err), 32'd1);
    check("bd_rdata", got_rdata,    32'd0);

    // Long read aborted by BERR on the first word
    DTACK = 1'b1;
    run_req(1'b0, 2'b10, 24'h000400, 32'h0, 3);
    check("lb_falls", 32'(as_falls), 32'd1);
    check("lb_err",   32'(got_err),  32'd1);

    // Reset while waiting for DTACK
    req = 1'b1; we = 1'b1; size = 2'b01; addr = 24'h000100; wdata = 32'h1111;
    for (int i = 0; i < 20 && AS; i++) begin
      @(posedge CLK); #1;
    end
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b1; req = 1'b0;
    @(posedge CLK); #1;
    check("rw_as",  32'(AS), 32'd1);
    check("rw_ds",  32'({UDS, LDS}), 32'd3);
    check("rw_d",   32'(D), 32'h0000FFFF);
    RESET = 1'b0;
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge CLK); #1;
      if (ack) ack_seen++;
    end
    check("rw_noack", 32'(ack_seen), 32'd0);

`ifdef V68K_BUS_TIMEOUT_EN
    // No termination at all: the timeout must end the cycle
    run_req(1'b0, 2'b01, 24'h000100, 32'h0, -1);
    check("to_ack", 32'(got_ack), 32'd1);
    check("to_err", 32'(got_err), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
